// File: rtl/fila_sched_pkg.sv
// Shared types for the fila scheduler: enqueue FSM states and arbiter grant sides.
package fila_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAPT,
        PEND
    } enq_state_t;

    typedef enum logic {
        GRANT_ENQ,
        GRANT_DEQ
    } grant_t;

    // Round-robin winner when both sides are eligible: the side not granted last.
    function automatic grant_t rr_pick(input grant_t last_grant);
        return (last_grant == GRANT_DEQ) ? GRANT_ENQ : GRANT_DEQ;
    endfunction

endpackage

// File: rtl/fila_scheduler_tick_gen.sv
// Divides the 1 MHz clock into a fast and a slow single-cycle enable, the slow one
// always coinciding with a fast one.
module fila_scheduler_tick_gen #(
    parameter int unsigned DIV_FAST = 10,
    parameter int unsigned DIV_SLOW = 10
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_fast_o,
    output logic tick_slow_o
);

    localparam int unsigned FW = (DIV_FAST > 1) ? $clog2(DIV_FAST) : 1;
    localparam int unsigned SW = (DIV_SLOW > 1) ? $clog2(DIV_SLOW) : 1;
    localparam logic [FW-1:0] FAST_MAX = FW'(DIV_FAST - 1);
    localparam logic [SW-1:0] SLOW_MAX = SW'(DIV_SLOW - 1);

    logic [FW-1:0] cnt_f_q, cnt_f_d;
    logic [SW-1:0] cnt_s_q, cnt_s_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_f_q <= '0;
            cnt_s_q <= '0;
        end else begin
            cnt_f_q <= cnt_f_d;
            cnt_s_q <= cnt_s_d;
        end
    end

    always_comb begin
        tick_fast_o = (cnt_f_q == FAST_MAX);
        tick_slow_o = tick_fast_o && (cnt_s_q == SLOW_MAX);
        cnt_f_d     = tick_fast_o ? '0 : cnt_f_q + FW'(1);
        cnt_s_d     = cnt_s_q;
        if (tick_fast_o) begin
            cnt_s_d = (cnt_s_q == SLOW_MAX) ? '0 : cnt_s_q + SW'(1);
        end
    end

endmodule

// File: rtl/fila_scheduler.sv
// Deserializer-to-queue sequencer: captures and acknowledges bytes, then arbitrates
// one queue operation per slow slot between enqueue and dequeue, round-robin.
module fila_scheduler #(
    parameter int unsigned DIV_FAST = 10,
    parameter int unsigned DIV_SLOW = 10,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned LEN_W    = 4
) (
    input  logic             clock1M,
    input  logic             reset,
    input  logic             data_ready_in,
    input  logic [7:0]       des_data_in,
    input  logic             dequeue_in,
    input  logic [LEN_W-1:0] len_in,
    output logic             tick_fast_out,
    output logic             tick_slow_out,
    output logic             ack_out,
    output logic             enqueue_out,
    output logic             dequeue_out,
    output logic [7:0]       q_data_out,
    output logic             busy_out,
    output logic             underflow_out
);

    import fila_sched_pkg::*;

    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

    enq_state_t state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic       deq_pend_q, deq_pend_d;
    grant_t     last_grant_q, last_grant_d;

    logic enq_ok, deq_ok;
    logic grant_enq, grant_deq;

    fila_scheduler_tick_gen #(
        .DIV_FAST (DIV_FAST),
        .DIV_SLOW (DIV_SLOW)
    ) u_tick_gen (
        .clk_i       (clock1M),
        .rst_ni      (reset),
        .tick_fast_o (tick_fast_out),
        .tick_slow_o (tick_slow_out)
    );

    always_ff @(posedge clock1M or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            deq_pend_q   <= 1'b0;
            last_grant_q <= GRANT_DEQ;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            deq_pend_q   <= deq_pend_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Slot arbiter: at most one grant per slow tick; len_in is sampled in that cycle.
    always_comb begin
        enq_ok        = (state_q == PEND) && (len_in < DEPTH_L);
        deq_ok        = deq_pend_q && (len_in != '0);
        grant_enq     = 1'b0;
        grant_deq     = 1'b0;
        underflow_out = 1'b0;
        if (tick_slow_out) begin
            if (enq_ok && deq_ok) begin
                if (rr_pick(last_grant_q) == GRANT_ENQ) begin
                    grant_enq = 1'b1;
                end else begin
                    grant_deq = 1'b1;
                end
            end else if (enq_ok) begin
                grant_enq = 1'b1;
            end else if (deq_ok) begin
                grant_deq = 1'b1;
            end
            underflow_out = deq_pend_q && (len_in == '0);
        end
    end

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        last_grant_d = last_grant_q;
        ack_out      = 1'b0;
        enqueue_out  = 1'b0;
        busy_out     = (state_q == PEND);

        unique case (state_q)
            IDLE: begin
                if (data_ready_in) begin
                    hold_d  = des_data_in;
                    state_d = CAPT;
                end
            end
            CAPT: begin
                if (tick_fast_out) begin
                    ack_out = 1'b1;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (grant_enq) begin
                    enqueue_out = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant_enq) begin
            last_grant_d = GRANT_ENQ;
        end else if (grant_deq) begin
            last_grant_d = GRANT_DEQ;
        end

        dequeue_out = grant_deq;
        // A pulse arriving in the serving cycle opens a fresh request.
        deq_pend_d  = (deq_pend_q && !grant_deq && !underflow_out) || dequeue_in;
        q_data_out  = enqueue_out ? hold_q : '0;
    end

endmodule
